// File: rtl/out_bank.sv
// Output register bank: captures the ten upper-triangle results into primary slots,
// snapshots a complete frame into a shadow buffer and drains it over valid/ready.
module out_bank #(
    parameter int DW = 16
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic [3:0]    ouputcon,
    input  logic          out_gate,
    input  logic          out_sclr,
    input  logic [DW-1:0] acc_data,
    input  logic          o_ready,
    output logic          o_valid,
    output logic [DW-1:0] o_data,
    output logic [3:0]    o_idx,
    output logic          o_last,
    output logic          frame_done,
    output logic          busy,
    output logic          ovf
);
    typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;

    state_t        state_q;
    logic [DW-1:0] prim_q   [1:10];
    logic [DW-1:0] shadow_q [1:10];
    logic [10:1]   mask_q;
    logic [10:1]   mask_d;
    logic [10:1]   sel;
    logic [10:1]   wr_en;
    logic          o_valid_q;
    logic [DW-1:0] o_data_q;
    logic [3:0]    o_idx_q;
    logic          o_last_q;
    logic          frame_done_q;
    logic          busy_q;
    logic          ovf_q;

    logic          slot_ok;
    logic          store_req;
    logic          full;
    logic          copy;
    logic          store_ok;
    logic          ovf_set;
    logic [3:0]    nxt_idx;
    logic [DW-1:0] nxt_word;

    assign slot_ok   = (ouputcon >= 4'd1) && (ouputcon <= 4'd10);
    assign store_req = out_gate && slot_ok;
    assign full      = &mask_q;
    assign copy      = (state_q == S_IDLE) && full;
    // A complete frame blocks new stores until it has been moved to the shadow.
    assign store_ok  = store_req && !out_sclr && (!full || copy);
    assign ovf_set   = (store_req || out_sclr) && full && !copy;

    genvar gi;
    generate
        for (gi = 1; gi <= 10; gi++) begin : g_sel
            assign sel[gi]   = (ouputcon == 4'(gi));
            assign wr_en[gi] = store_ok && sel[gi];
        end
    endgenerate

    always_comb begin
        mask_d = mask_q;
        if (out_sclr || copy) begin
            mask_d = '0;
        end
        mask_d = mask_d | wr_en;
    end

    assign nxt_idx = o_idx_q + 4'd1;

    always_comb begin
        nxt_word = '0;
        for (int k = 1; k <= 10; k++) begin
            if (nxt_idx == k[3:0]) begin
                nxt_word = shadow_q[k];
            end
        end
    end

    always_ff @(posedge CLK) begin
        for (int k = 1; k <= 10; k++) begin
            if (reset) begin
                prim_q[k]   <= '0;
                shadow_q[k] <= '0;
            end else begin
                if (out_sclr) begin
                    prim_q[k] <= '0;
                end else if (wr_en[k]) begin
                    prim_q[k] <= acc_data;
                end
                if (copy) begin
                    shadow_q[k] <= prim_q[k];
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q      <= S_IDLE;
            mask_q       <= '0;
            o_valid_q    <= 1'b0;
            o_data_q     <= '0;
            o_idx_q      <= 4'd0;
            o_last_q     <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            mask_q <= mask_d;
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    frame_done_q <= 1'b0;
                    if (copy) begin
                        // Shadow is loaded this edge, so the first word comes from primary.
                        state_q   <= S_SEND;
                        o_valid_q <= 1'b1;
                        o_idx_q   <= 4'd1;
                        o_data_q  <= prim_q[1];
                        o_last_q  <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (o_ready) begin
                        if (o_idx_q == 4'd10) begin
                            state_q      <= S_DONE;
                            o_valid_q    <= 1'b0;
                            o_last_q     <= 1'b0;
                            o_idx_q      <= 4'd0;
                            o_data_q     <= '0;
                            frame_done_q <= 1'b1;
                        end else begin
                            o_idx_q  <= nxt_idx;
                            o_data_q <= nxt_word;
                            o_last_q <= (nxt_idx == 4'd10);
                        end
                    end
                end
                S_DONE: begin
                    state_q      <= S_IDLE;
                    frame_done_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_valid    = o_valid_q;
    assign o_data     = o_data_q;
    assign o_idx      = o_idx_q;
    assign o_last     = o_last_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;
    assign ovf        = ovf_q;
endmodule

// File: tb/tb_out_bank.sv
// Directed bench for out_bank: frame capture, shadow drain, back-pressure, clear,
// overflow, invalid slot selects and mid-stream reset.
module tb_out_bank;
    logic        CLK;
    logic        reset;
    logic [3:0]  ouputcon;
    logic        out_gate;
    logic        out_sclr;
    logic [15:0] acc_data;
    logic        o_ready;
    logic        o_valid;
    logic [15:0] o_data;
    logic [3:0]  o_idx;
    logic        o_last;
    logic        frame_done;
    logic        busy;
    logic        ovf;

    int tests = 0;
    int fails = 0;

    logic [15:0] fa [1:10];
    logic [15:0] fb [1:10];
    logic [15:0] exp_v [1:10];
    logic [15:0] got_data [0:15];
    logic [3:0]  got_idx [0:15];
    logic        got_last [0:15];
    int n_xfer, n_fd, n_unstable;

    out_bank #(.DW(16)) dut (
        .CLK(CLK), .reset(reset), .ouputcon(ouputcon), .out_gate(out_gate),
        .out_sclr(out_sclr), .acc_data(acc_data), .o_ready(o_ready),
        .o_valid(o_valid), .o_data(o_data), .o_idx(o_idx), .o_last(o_last),
        .frame_done(frame_done), .busy(busy), .ovf(ovf)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic store(input logic [3:0] s, input logic [15:0] d);
        ouputcon = s;
        acc_data = d;
        out_gate = 1'b1;
        step();
        out_gate = 1'b0;
        ouputcon = 4'd0;
    endtask

    // Collects up to ten transfers; mode 0 holds o_ready high, mode 1 uses 1,0,0,...
    task automatic drain(input int mode);
        logic        have_prev;
        logic [3:0]  prev_idx;
        logic [15:0] prev_data;
        n_xfer = 0; n_fd = 0; n_unstable = 0; have_prev = 1'b0;
        prev_idx = 4'd0; prev_data = 16'd0;
        for (int c = 0; c < 200 && n_xfer < 10; c++) begin
            o_ready = (mode == 0) ? 1'b1 : ((c % 3) == 0);
            if (o_valid) begin
                if (have_prev && (o_idx !== prev_idx || o_data !== prev_data)) n_unstable++;
                if (o_ready) begin
                    got_idx[n_xfer] = o_idx;
                    got_data[n_xfer] = o_data;
                    got_last[n_xfer] = o_last;
                    n_xfer++;
                    have_prev = 1'b0;
                end else begin
                    have_prev = 1'b1;
                    prev_idx = o_idx;
                    prev_data = o_data;
                end
            end
            step();
            if (frame_done) n_fd++;
        end
        o_ready = 1'b0;
        repeat (2) begin
            step();
            if (frame_done) n_fd++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        tests++;
        if (o_valid !== 1'b0 || o_idx !== 4'd0 || o_data !== 16'd0 || o_last !== 1'b0) begin
            fails++;
            $display("FAIL reset_stream: valid=%b idx=%0d data=%h last=%b, want 0 0 0000 0",
                     o_valid, o_idx, o_data, o_last);
        end
        tests++;
        if (frame_done !== 1'b0 || busy !== 1'b0 || ovf !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags: frame_done=%b busy=%b ovf=%b, want 0 0 0", frame_done, busy, ovf);
        end
    endtask

    task automatic test_full_frame();
        for (int k = 1; k <= 10; k++) store(k[3:0], fa[k]);
        tests++;
        if (o_valid !== 1'b0) begin
            fails++;
            $display("FAIL latency_e: o_valid=%b at 10th store edge, want 0", o_valid);
        end
        step();
        tests++;
        if (o_valid !== 1'b1 || o_idx !== 4'd1 || o_data !== 16'h0011 || busy !== 1'b1) begin
            fails++;
            $display("FAIL latency_e1: valid=%b idx=%0d data=%h busy=%b, want 1 1 0011 1",
                     o_valid, o_idx, o_data, busy);
        end
        drain(0);
        tests++;
        if (n_xfer !== 10 || n_fd !== 1) begin
            fails++;
            $display("FAIL full_count: xfers=%0d frame_done=%0d, want 10 1", n_xfer, n_fd);
        end
        for (int k = 0; k < 10; k++) begin
            tests++;
            if (got_idx[k] !== 4'(k + 1) || got_data[k] !== fa[k+1] || got_last[k] !== (k == 9)) begin
                fails++;
                $display("FAIL full_word%0d: idx=%0d data=%h last=%b, want %0d %h %b",
                         k, got_idx[k], got_data[k], got_last[k], k + 1, fa[k+1], k == 9);
            end
        end
    endtask

    task automatic test_ready_toggle();
        for (int k = 1; k <= 10; k++) store(k[3:0], fa[k]);
        step();
        drain(1);
        tests++;
        if (n_xfer !== 10 || n_fd !== 1 || n_unstable !== 0) begin
            fails++;
            $display("FAIL toggle_count: xfers=%0d frame_done=%0d unstable=%0d, want 10 1 0",
                     n_xfer, n_fd, n_unstable);
        end
        for (int k = 0; k < 10; k++) begin
            tests++;
            if (got_idx[k] !== 4'(k + 1) || got_data[k] !== fa[k+1]) begin
                fails++;
                $display("FAIL toggle_word%0d: idx=%0d data=%h, want %0d %h",
                         k, got_idx[k], got_data[k], k + 1, fa[k+1]);
            end
        end
    endtask

    task automatic test_sclr_partial();
        for (int k = 1; k <= 6; k++) store(k[3:0], 16'h0100 + 16'(k));
        out_sclr = 1'b1;
        step();
        out_sclr = 1'b0;
        // Only 7..10 now; an uncleared mask would complete the frame here.
        for (int k = 7; k <= 10; k++) store(k[3:0], fa[k]);
        step();
        step();
        tests++;
        if (o_valid !== 1'b0 || ovf !== 1'b0) begin
            fails++;
            $display("FAIL sclr_partial: o_valid=%b ovf=%b, want 0 0", o_valid, ovf);
        end
        for (int k = 1; k <= 6; k++) store(k[3:0], fb[k]);
        step();
        drain(0);
        for (int k = 1; k <= 10; k++) exp_v[k] = (k <= 6) ? fb[k] : fa[k];
        tests++;
        if (n_xfer !== 10 || n_fd !== 1) begin
            fails++;
            $display("FAIL sclr_count: xfers=%0d frame_done=%0d, want 10 1", n_xfer, n_fd);
        end
        for (int k = 0; k < 10; k++) begin
            tests++;
            if (got_idx[k] !== 4'(k + 1) || got_data[k] !== exp_v[k+1]) begin
                fails++;
                $display("FAIL sclr_word%0d: idx=%0d data=%h, want %0d %h",
                         k, got_idx[k], got_data[k], k + 1, exp_v[k+1]);
            end
        end
    endtask

    task automatic test_overflow();
        o_ready = 1'b0;
        for (int k = 1; k <= 10; k++) store(k[3:0], fa[k]);
        step();
        for (int k = 1; k <= 10; k++) store(k[3:0], fb[k]);
        tests++;
        if (ovf !== 1'b0) begin
            fails++;
            $display("FAIL ovf_early: ovf=%b after frame 2 fill, want 0", ovf);
        end
        store(4'd3, 16'hBEEF);
        tests++;
        if (ovf !== 1'b1) begin
            fails++;
            $display("FAIL ovf_set: ovf=%b after 11th store, want 1", ovf);
        end
        drain(0);
        tests++;
        if (n_xfer !== 10 || n_fd !== 1) begin
            fails++;
            $display("FAIL ovf_f1_count: xfers=%0d frame_done=%0d, want 10 1", n_xfer, n_fd);
        end
        for (int k = 0; k < 10; k++) begin
            tests++;
            if (got_idx[k] !== 4'(k + 1) || got_data[k] !== fa[k+1]) begin
                fails++;
                $display("FAIL ovf_f1_word%0d: idx=%0d data=%h, want %0d %h",
                         k, got_idx[k], got_data[k], k + 1, fa[k+1]);
            end
        end
        drain(0);
        tests++;
        if (n_xfer !== 10 || n_fd !== 1 || ovf !== 1'b1) begin
            fails++;
            $display("FAIL ovf_f2_count: xfers=%0d frame_done=%0d ovf=%b, want 10 1 1", n_xfer, n_fd, ovf);
        end
        for (int k = 0; k < 10; k++) begin
            tests++;
            if (got_idx[k] !== 4'(k + 1) || got_data[k] !== fb[k+1]) begin
                fails++;
                $display("FAIL ovf_f2_word%0d: idx=%0d data=%h, want %0d %h",
                         k, got_idx[k], got_data[k], k + 1, fb[k+1]);
            end
        end
    endtask

    task automatic test_gate();
        for (int k = 1; k <= 10; k++) if (k != 5) store(k[3:0], fa[k]);
        acc_data = 16'hDEAD;
        ouputcon = 4'd5;  out_gate = 1'b0; step();
        ouputcon = 4'd0;  out_gate = 1'b1; step();
        ouputcon = 4'd12; out_gate = 1'b1; step();
        out_gate = 1'b0;  ouputcon = 4'd0;
        step();
        step();
        tests++;
        if (o_valid !== 1'b0) begin
            fails++;
            $display("FAIL gate_nomask: o_valid=%b with slot 5 unwritten, want 0", o_valid);
        end
        store(4'd5, fa[5]);
        step();
        drain(0);
        tests++;
        if (n_xfer !== 10 || n_fd !== 1) begin
            fails++;
            $display("FAIL gate_count: xfers=%0d frame_done=%0d, want 10 1", n_xfer, n_fd);
        end
        for (int k = 0; k < 10; k++) begin
            tests++;
            if (got_idx[k] !== 4'(k + 1) || got_data[k] !== fa[k+1]) begin
                fails++;
                $display("FAIL gate_word%0d: idx=%0d data=%h, want %0d %h",
                         k, got_idx[k], got_data[k], k + 1, fa[k+1]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int fd_seen;
        for (int k = 1; k <= 10; k++) store(k[3:0], fb[k]);
        step();
        o_ready = 1'b1;
        repeat (3) step();
        o_ready = 1'b0;
        tests++;
        if (o_idx !== 4'd4 || o_data !== fb[4] || o_valid !== 1'b1) begin
            fails++;
            $display("FAIL mid_pos: idx=%0d data=%h valid=%b, want 4 %h 1", o_idx, o_data, o_valid, fb[4]);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        tests++;
        if (o_valid !== 1'b0 || o_idx !== 4'd0 || ovf !== 1'b0 || frame_done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset: valid=%b idx=%0d ovf=%b fd=%b busy=%b, want 0 0 0 0 0",
                     o_valid, o_idx, ovf, frame_done, busy);
        end
        fd_seen = 0;
        repeat (4) begin
            step();
            if (frame_done || o_valid) fd_seen++;
        end
        tests++;
        if (fd_seen !== 0) begin
            fails++;
            $display("FAIL mid_quiet: %0d cycles with frame_done/o_valid after reset, want 0", fd_seen);
        end
        for (int k = 1; k <= 10; k++) store(k[3:0], fa[k]);
        step();
        drain(0);
        tests++;
        if (n_xfer !== 10 || n_fd !== 1) begin
            fails++;
            $display("FAIL mid_count: xfers=%0d frame_done=%0d, want 10 1", n_xfer, n_fd);
        end
        for (int k = 0; k < 10; k++) begin
            tests++;
            if (got_idx[k] !== 4'(k + 1) || got_data[k] !== fa[k+1]) begin
                fails++;
                $display("FAIL mid_word%0d: idx=%0d data=%h, want %0d %h",
                         k, got_idx[k], got_data[k], k + 1, fa[k+1]);
            end
        end
    endtask

    initial begin
        reset = 1'b1; ouputcon = 4'd0; out_gate = 1'b0; out_sclr = 1'b0;
        acc_data = 16'd0; o_ready = 1'b0;
        fa[1] = 16'h0011; fa[2] = 16'h0012; fa[3] = 16'h0013; fa[4]  = 16'h0014;
        fa[5] = 16'h0022; fa[6] = 16'h0023; fa[7] = 16'h0024; fa[8]  = 16'h0033;
        fa[9] = 16'h0034; fa[10] = 16'h0044;
        for (int k = 1; k <= 10; k++) fb[k] = 16'hA000 + 16'(k * 16'h0101);
        test_reset();
        test_full_frame();
        test_ready_toggle();
        test_sclr_partial();
        test_overflow();
        test_gate();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
